// File: rtl/game_flow_ctrl_pkg.sv
// Shared definitions for the game flow sequencer.
// Holds the FSM state encoding (also decoded by the LED/LCD blocks from
// o_state), default timing constants and the tick-counter width helper.
package game_flow_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_PLAY      = 3'd2,
      ST_RESULT    = 3'd3
   } game_state_e;

   localparam int unsigned DEF_CD_STEP_MS     = 1000;
   localparam int unsigned DEF_CD_STEPS       = 3;
   localparam int unsigned DEF_RESULT_HOLD_MS = 2000;
   localparam int unsigned DEF_SCORE_W        = 16;

   // Wide enough to hold the larger of the two terminal values without wrapping.
   function automatic int unsigned tick_cnt_width(int unsigned a, int unsigned b);
      return $clog2(((a > b) ? a : b) + 1);
   endfunction

endpackage

// File: rtl/game_flow_ctrl_ms_tick_counter.sv
// Saturating millisecond tick counter.
// Ports:
//   clk, rst     clock, async active-low reset
//   i_clr        synchronous clear to 0 (wins over counting)
//   i_en         counting enable
//   i_tick       1 ms strobe
//   i_term       terminal value; the count saturates there
//   o_count      current count
//   o_done       strobe on the tick that brings the count to i_term
module ms_tick_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic         i_tick,
   input  logic [W-1:0] i_term,
   output logic [W-1:0] o_count,
   output logic         o_done
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;
   logic         step;

   assign step = i_en & i_tick & (count_q < i_term);

   always_comb begin
      count_d = count_q;
      if (i_clr) begin
         count_d = '0;
      end else if (step) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Independent of i_clr so the owner may clear on this very strobe.
   assign o_done  = step & (count_q == (i_term - W'(1)));
   assign o_count = count_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: IDLE -> 3-2-1 COUNTDOWN -> PLAY -> RESULT.
// Ports:
//   clk, rst       system clock, async active-low reset
//   i_tick         1 ms strobe
//   i_start        start pulse (accepted in IDLE only)
//   i_restart      restart pulse (abort / replay)
//   i_game_end     chart-finished level; its rising edge ends PLAY
//   i_score        current total score
//   o_game_start   high in PLAY
//   o_soft_clr     one-clk clear pulse for downstream blocks
//   o_cd_active    high in COUNTDOWN
//   o_cd_digit     countdown digit, 0 outside COUNTDOWN
//   o_best_score   session best score (cleared by rst only)
//   o_new_best     high in RESULT when this round set a new best
//   o_state        encoded FSM state
module game_flow_ctrl
   import game_flow_pkg::*;
#(
   parameter int unsigned CD_STEP_MS     = DEF_CD_STEP_MS,
   parameter int unsigned CD_STEPS       = DEF_CD_STEPS,
   parameter int unsigned RESULT_HOLD_MS = DEF_RESULT_HOLD_MS,
   parameter int unsigned SCORE_W        = DEF_SCORE_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_tick,
   input  logic               i_start,
   input  logic               i_restart,
   input  logic               i_game_end,
   input  logic [SCORE_W-1:0] i_score,
   output logic               o_game_start,
   output logic               o_soft_clr,
   output logic               o_cd_active,
   output logic [1:0]         o_cd_digit,
   output logic [SCORE_W-1:0] o_best_score,
   output logic               o_new_best,
   output logic [2:0]         o_state
);

   localparam int unsigned CNT_W = tick_cnt_width(CD_STEP_MS, RESULT_HOLD_MS);
   localparam logic [CNT_W-1:0] CD_TERM   = CNT_W'(CD_STEP_MS);
   localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(RESULT_HOLD_MS);

   game_state_e        state_q;
   logic               game_start_q;
   logic               soft_clr_q;
   logic               cd_active_q;
   logic [1:0]         cd_digit_q;
   logic [SCORE_W-1:0] best_q;
   logic               new_best_q;
   logic               ge_q;

   logic               enter_cd;
   logic               cd_expire;
   logic               end_play;
   logic               ge_rise;
   logic               cnt_clr;
   logic               cnt_en;
   logic [CNT_W-1:0]   cnt_term;
   logic [CNT_W-1:0]   cnt;
   logic               cnt_done;
   logic               hold_sat;

   ms_tick_counter #(
      .W (CNT_W)
   ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (cnt_clr),
      .i_en    (cnt_en),
      .i_tick  (i_tick),
      .i_term  (cnt_term),
      .o_count (cnt),
      .o_done  (cnt_done)
   );

   always_comb begin
      hold_sat  = (cnt == HOLD_TERM);
      ge_rise   = i_game_end & ~ge_q;
      enter_cd  = ((state_q == ST_IDLE) && i_start)
               || (((state_q == ST_COUNTDOWN) || (state_q == ST_PLAY)) && i_restart)
               || ((state_q == ST_RESULT) && i_restart && hold_sat);
      cd_expire = (state_q == ST_COUNTDOWN) && cnt_done;
      // Restart takes priority over a coincident game_end edge.
      end_play  = (state_q == ST_PLAY) && ge_rise && !i_restart;
      cnt_clr   = enter_cd || cd_expire || end_play;
      cnt_en    = (state_q == ST_COUNTDOWN) || (state_q == ST_RESULT);
      cnt_term  = (state_q == ST_COUNTDOWN) ? CD_TERM : HOLD_TERM;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         game_start_q <= 1'b0;
         soft_clr_q   <= 1'b0;
         cd_active_q  <= 1'b0;
         cd_digit_q   <= '0;
         best_q       <= '0;
         new_best_q   <= 1'b0;
         ge_q         <= 1'b0;
      end else begin
         // Tracking every cycle also preloads the edge detector on soft_clr,
         // so a level still high from the previous round is not an edge.
         ge_q       <= i_game_end;
         soft_clr_q <= 1'b0;
         if (enter_cd) begin
            state_q      <= ST_COUNTDOWN;
            soft_clr_q   <= 1'b1;
            cd_active_q  <= 1'b1;
            cd_digit_q   <= 2'(CD_STEPS);
            game_start_q <= 1'b0;
            new_best_q   <= 1'b0;
         end else begin
            case (state_q)
               ST_COUNTDOWN: begin
                  if (cd_expire) begin
                     if (cd_digit_q == 2'd1) begin
                        state_q      <= ST_PLAY;
                        game_start_q <= 1'b1;
                        cd_active_q  <= 1'b0;
                        cd_digit_q   <= '0;
                     end else begin
                        cd_digit_q <= cd_digit_q - 2'd1;
                     end
                  end
               end
               ST_PLAY: begin
                  if (end_play) begin
                     state_q      <= ST_RESULT;
                     game_start_q <= 1'b0;
                     if (i_score > best_q) begin
                        best_q     <= i_score;
                        new_best_q <= 1'b1;
                     end else begin
                        new_best_q <= 1'b0;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign o_state      = state_q;
   assign o_game_start = game_start_q;
   assign o_soft_clr   = soft_clr_q;
   assign o_cd_active  = cd_active_q;
   assign o_cd_digit   = cd_digit_q;
   assign o_best_score = best_q;
   assign o_new_best   = new_best_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
module tb_game_flow_ctrl;

   localparam int CD   = 4;
   localparam int STEPS = 3;
   localparam int HOLD = 5;
   localparam int SW   = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          tick, start, restart, ge;
   logic [SW-1:0] score;
   logic          o_game_start, o_soft_clr, o_cd_active, o_new_best;
   logic [1:0]    o_cd_digit;
   logic [SW-1:0] o_best_score;
   logic [2:0]    o_state;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: mode 0..3, total countdown ticks elapsed, result hold ticks.
   int            m_mode, m_elapsed, m_hold;
   logic [SW-1:0] m_best;
   bit            m_nb, m_prev_ge, m_soft;

   game_flow_ctrl #(
      .CD_STEP_MS     (CD),
      .CD_STEPS       (STEPS),
      .RESULT_HOLD_MS (HOLD),
      .SCORE_W        (SW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_tick       (tick),
      .i_start      (start),
      .i_restart    (restart),
      .i_game_end   (ge),
      .i_score      (score),
      .o_game_start (o_game_start),
      .o_soft_clr   (o_soft_clr),
      .o_cd_active  (o_cd_active),
      .o_cd_digit   (o_cd_digit),
      .o_best_score (o_best_score),
      .o_new_best   (o_new_best),
      .o_state      (o_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_elapsed = 0; m_hold = 0;
      m_best = '0; m_nb = 0; m_prev_ge = 0; m_soft = 0;
   endtask

   task automatic model_step();
      bit rise, enter;
      if (!rst) begin
         model_reset();
         return;
      end
      rise      = ge && !m_prev_ge;
      m_prev_ge = ge;
      m_soft    = 0;
      enter = (m_mode == 0 && start) || ((m_mode == 1 || m_mode == 2) && restart)
           || (m_mode == 3 && restart && m_hold >= HOLD);
      if (enter) begin
         m_mode = 1; m_elapsed = 0; m_soft = 1; m_nb = 0;
      end else if (m_mode == 1) begin
         if (tick) begin
            m_elapsed++;
            if (m_elapsed == STEPS * CD) m_mode = 2;
         end
      end else if (m_mode == 2) begin
         if (rise) begin
            m_mode = 3; m_hold = 0;
            m_nb = (score > m_best);
            if (m_nb) m_best = score;
         end
      end else if (m_mode == 3) begin
         if (tick && m_hold < HOLD) m_hold++;
      end
   endtask

   task automatic compare_all();
      check("state",      o_state,      m_mode);
      check("game_start", o_game_start, m_mode == 2);
      check("cd_active",  o_cd_active,  m_mode == 1);
      check("cd_digit",   o_cd_digit,   (m_mode == 1) ? STEPS - m_elapsed / CD : 0);
      check("soft_clr",   o_soft_clr,   m_soft);
      check("best",       o_best_score, m_best);
      check("new_best",   o_new_best,   m_mode == 3 && m_nb);
   endtask

   task automatic step_cycle(input bit t, input bit s, input bit r, input bit g);
      tick = t; start = s; restart = r; ge = g;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      tick = 0; start = 0; restart = 0;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) step_cycle(1, 0, 0, ge);
   endtask

   initial begin
      bit g_lvl;
      rst = 0; tick = 0; start = 0; restart = 0; ge = 0; score = '0;
      model_reset();
      #23;
      compare_all();
      rst = 1;
      step_cycle(0, 0, 0, 0);

      // Start and 3-2-1 countdown
      step_cycle(0, 1, 0, 0);
      check("start_soft_clr", o_soft_clr, 1);
      check("start_digit", o_cd_digit, 3);
      step_cycle(0, 0, 0, 0);
      check("soft_clr_1clk", o_soft_clr, 0);
      for (int i = 1; i <= 12; i++) begin
         step_cycle(1, 0, 0, 0);
         check("cd_gs", o_game_start, i == 12);
         check("cd_dig", o_cd_digit, (i < 12) ? 3 - i / 4 : 0);
      end

      // First round ends with a new best
      score = 16'd120;
      step_cycle(0, 0, 0, 1);
      check("r1_state", o_state, 3);
      check("r1_best", o_best_score, 120);
      check("r1_new_best", o_new_best, 1);

      // Replay with game_end still high: stale level must not end PLAY
      tick_n(5);
      step_cycle(0, 0, 1, 1);
      check("replay_state", o_state, 1);
      tick_n(12);
      repeat (3) step_cycle(0, 0, 0, 1);
      check("stale_ge_play", o_state, 2);
      step_cycle(0, 0, 0, 0);
      step_cycle(0, 0, 0, 1);
      check("r2_state", o_state, 3);
      check("r2_equal_nb", o_new_best, 0);
      check("r2_best", o_best_score, 120);

      // RESULT hold: restart ignored before saturation
      tick_n(3);
      step_cycle(0, 0, 1, 1);
      check("hold3_ignored", o_state, 3);
      tick_n(1);
      step_cycle(0, 0, 1, 1);
      check("hold4_ignored", o_state, 3);
      check("hold4_no_clr", o_soft_clr, 0);
      tick_n(1);
      step_cycle(0, 0, 1, 1);
      check("hold5_accept", o_state, 1);
      check("hold5_clr", o_soft_clr, 1);
      check("hold5_digit", o_cd_digit, 3);

      // Restart and game_end edge together in PLAY
      tick_n(12);
      step_cycle(0, 0, 0, 0);
      score = 16'd500;
      step_cycle(0, 0, 1, 1);
      check("race_state", o_state, 1);
      check("race_best", o_best_score, 120);
      check("race_clr", o_soft_clr, 1);

      // Async reset mid-PLAY
      tick_n(12);
      check("pre_rst_play", o_state, 2);
      #2;
      rst = 0;
      #1;
      check("arst_state", o_state, 0);
      check("arst_gs", o_game_start, 0);
      check("arst_best", o_best_score, 0);
      check("arst_misc", {o_soft_clr, o_cd_active, o_cd_digit, o_new_best}, 0);
      model_reset();
      step_cycle(0, 0, 0, ge);
      rst = 1;
      step_cycle(0, 0, 0, ge);

      // Randomized traffic against the model
      g_lvl = ge;
      for (int i = 0; i < 3000; i++) begin
         bit t, s, r;
         t = ($urandom_range(0, 1) == 1);
         s = ($urandom_range(0, 19) == 0);
         r = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 15) == 0) g_lvl = ~g_lvl;
         if ($urandom_range(0, 7) == 0)
            score = ($urandom_range(0, 2) == 0) ? m_best : SW'($urandom_range(0, 300));
         step_cycle(t, s, r, g_lvl);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
